// File: rtl/hazard_ctrl.sv
// Hazard/redirect control for the five-stage pipeline: load-use bubbles,
// branch/jump flushes, halt/resume sequencing, operand forwarding and perf counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_halt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic [4:0]       wb_rd,
    input  logic             mem_regwrite,
    input  logic             wb_regwrite,
    input  logic             go,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             load_use_s;
    logic             pc_en_s;
    logic             ifid_en_s;
    logic             ifid_clr_s;
    logic             idex_clr_s;
    logic             flush_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // MEM result is younger than WB, so it takes precedence; r0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_rd,
        input logic       m_we,
        input logic [4:0] w_rd,
        input logic       w_we
    );
        logic [1:0] sel;
        if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign load_use_s = ex_memread && (ex_rd != 5'd0) &&
                        ((id_uses_rs && (ex_rd == id_rs)) ||
                         (id_uses_rt && (ex_rd == id_rt)));

    // Prioritised control resolution and next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        pc_en_s     = 1'b1;
        ifid_en_s   = 1'b1;
        ifid_clr_s  = 1'b0;
        idex_clr_s  = 1'b0;
        flush_s     = 1'b0;
        if (!rst_n) begin
            state_nxt_s = ST_RUN;
            pc_en_s     = 1'b0;
            ifid_en_s   = 1'b0;
            ifid_clr_s  = 1'b1;
            idex_clr_s  = 1'b1;
        end else if (ex_redirect) begin
            ifid_clr_s = 1'b1;
            idex_clr_s = 1'b1;
            flush_s    = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (load_use_s || id_halt) begin
                        pc_en_s    = 1'b0;
                        ifid_en_s  = 1'b0;
                        idex_clr_s = 1'b1;
                        if (!load_use_s) begin
                            state_nxt_s = ST_HALT;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_HALT: begin
                    pc_en_s    = 1'b0;
                    ifid_en_s  = 1'b0;
                    idex_clr_s = 1'b1;
                    if (go) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_HALT;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!pc_en_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (flush_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
        end
    end

    assign pc_en     = pc_en_s;
    assign ifid_en   = ifid_en_s;
    assign ifid_clr  = ifid_clr_s;
    assign idex_clr  = idex_clr_s;
    assign fwd_a     = rst_n ? fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite) : 2'b00;
    assign fwd_b     = rst_n ? fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite) : 2'b00;
    assign halted    = rst_n && (state_r == ST_HALT);
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (4-bit counters so saturation is reachable).
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic             id_uses_rs, id_uses_rt, id_halt, ex_memread, ex_redirect;
    logic             mem_regwrite, wb_regwrite, go;
    logic             pc_en, ifid_en, ifid_clr, idex_clr, halted;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_halt(id_halt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .go(go), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input string tag, input logic p, input logic ie, input logic ic, input logic xc);
        chk({tag, ".pc_en"}, {31'd0, pc_en}, {31'd0, p});
        chk({tag, ".ifid_en"}, {31'd0, ifid_en}, {31'd0, ie});
        chk({tag, ".ifid_clr"}, {31'd0, ifid_clr}, {31'd0, ic});
        chk({tag, ".idex_clr"}, {31'd0, idex_clr}, {31'd0, xc});
    endtask

    task automatic clr_in();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_halt = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0; ex_redirect = 1'b0;
        mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b0; wb_regwrite = 1'b0; go = 1'b0;
    endtask

    initial begin
        clr_in();
        rst_n = 1'b0;
        mem_regwrite = 1'b1; mem_rd = 5'd3; ex_rs = 5'd3;
        #3;
        // reset values, forwarding forced to 00
        ctl("reset", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("reset.fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("reset.halted", {31'd0, halted}, 32'd0);
        chk("reset.stall", {28'd0, stall_cnt}, 32'd0);
        chk("reset.flush", {28'd0, flush_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        clr_in();
        go = 1'b1;  // ignored in RUN
        #1;
        ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("idle.halted", {31'd0, halted}, 32'd0);
        chk("idle.stall", {28'd0, stall_cnt}, 32'd0);
        go = 1'b0;

        // r0 load never stalls
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        ctl("lu_r0", 1'b1, 1'b1, 1'b0, 1'b0);
        // unused operand does not stall
        ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0;
        #1;
        ctl("lu_unused", 1'b1, 1'b1, 1'b0, 1'b0);
        // load-use through rs
        id_uses_rs = 1'b1;
        #1;
        ctl("lu", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("lu.stall", {28'd0, stall_cnt}, 32'd1);
        clr_in();
        mem_rd = 5'd5; mem_regwrite = 1'b1; ex_rs = 5'd5;
        #1;
        chk("lu.fwd_a", {30'd0, fwd_a}, 32'd2);
        ctl("lu.after", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("lu.after.stall", {28'd0, stall_cnt}, 32'd1);

        // redirect with simultaneous load-use (via rt)
        clr_in();
        ex_memread = 1'b1; ex_rd = 5'd6; id_rt = 5'd6; id_uses_rt = 1'b1; ex_redirect = 1'b1;
        #1;
        ctl("redir", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("redir.flush", {28'd0, flush_cnt}, 32'd1);
        chk("redir.stall", {28'd0, stall_cnt}, 32'd1);

        // halt entry
        clr_in();
        id_halt = 1'b1;
        #1;
        ctl("halt_acc", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("halt_acc.halted", {31'd0, halted}, 32'd0);
        tick();
        chk("halt.halted", {31'd0, halted}, 32'd1);
        chk("halt.stall", {28'd0, stall_cnt}, 32'd2);
        id_halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            ctl("halt_hold", 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        chk("halt_hold.stall", {28'd0, stall_cnt}, 32'd7);
        // redirect while halted flushes but keeps HALT
        ex_redirect = 1'b1;
        #1;
        ctl("halt_redir", 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        ex_redirect = 1'b0;
        chk("halt_redir.halted", {31'd0, halted}, 32'd1);
        chk("halt_redir.flush", {28'd0, flush_cnt}, 32'd2);
        chk("halt_redir.stall", {28'd0, stall_cnt}, 32'd7);
        for (int i = 0; i < 3; i++) tick();
        go = 1'b1;
        #1;
        ctl("go_cycle", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        go = 1'b0;
        chk("resume.halted", {31'd0, halted}, 32'd0);
        chk("resume.stall", {28'd0, stall_cnt}, 32'd11);
        ctl("resume", 1'b1, 1'b1, 1'b0, 1'b0);

        // halt coinciding with load-use does not enter HALT
        ex_memread = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1; id_halt = 1'b1;
        tick();
        chk("halt_lu.halted", {31'd0, halted}, 32'd0);
        chk("halt_lu.stall", {28'd0, stall_cnt}, 32'd12);
        clr_in();

        // forwarding priority
        ex_rt = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        #1;
        chk("fwd.mem", {30'd0, fwd_b}, 32'd2);
        mem_rd = 5'd0;
        #1;
        chk("fwd.wb", {30'd0, fwd_b}, 32'd1);
        wb_rd = 5'd0;
        #1;
        chk("fwd.none", {30'd0, fwd_b}, 32'd0);
        mem_rd = 5'd7; mem_regwrite = 1'b0; wb_rd = 5'd9; ex_rs = 5'd9;
        #1;
        chk("fwd.nowe_b", {30'd0, fwd_b}, 32'd0);
        chk("fwd.wb_a", {30'd0, fwd_a}, 32'd1);
        clr_in();

        // saturation
        ex_memread = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat.stall", {28'd0, stall_cnt}, 32'd15);
        clr_in();

        // async reset mid-HALT
        id_halt = 1'b1;
        tick();
        id_halt = 1'b0;
        chk("pre_rst.halted", {31'd0, halted}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.halted", {31'd0, halted}, 32'd0);
        chk("arst.stall", {28'd0, stall_cnt}, 32'd0);
        chk("arst.flush", {28'd0, flush_cnt}, 32'd0);
        ctl("arst", 1'b0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;
        #1;
        ctl("post_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("post_rst.halted", {31'd0, halted}, 32'd0);
        chk("post_rst.stall", {28'd0, stall_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
